// File: rtl/game_flow_ctrl_pkg.sv
// Shared state encodings, command codes and PS/2 scan codes
// for the game flow sequencer.
package game_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_TITLE     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_OVER_HOLD = 2'd2,
        ST_OVER      = 2'd3
    } state_t;

    localparam logic [3:0] CMD_NONE  = 4'd0;
    localparam logic [3:0] CMD_L     = 4'd1;
    localparam logic [3:0] CMD_R     = 4'd2;
    localparam logic [3:0] CMD_U     = 4'd3;
    localparam logic [3:0] CMD_D     = 4'd4;
    localparam logic [3:0] CMD_PLACE = 4'd5;
    localparam logic [3:0] CMD_ROT   = 4'd6;
    localparam logic [3:0] CMD_SEL1  = 4'd7;
    localparam logic [3:0] CMD_SEL2  = 4'd8;
    localparam logic [3:0] CMD_SEL3  = 4'd9;

    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_R     = 8'h2D;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;

    // CMD_NONE marks an unmapped scan code
    function automatic logic [3:0] decode_key(input logic [7:0] code);
        case (code)
            KEY_LEFT, KEY_A:  decode_key = CMD_L;
            KEY_RIGHT, KEY_D: decode_key = CMD_R;
            KEY_UP, KEY_W:    decode_key = CMD_U;
            KEY_DOWN, KEY_S:  decode_key = CMD_D;
            KEY_SPACE:        decode_key = CMD_PLACE;
            KEY_R:            decode_key = CMD_ROT;
            KEY_1:            decode_key = CMD_SEL1;
            KEY_2:            decode_key = CMD_SEL2;
            KEY_3:            decode_key = CMD_SEL3;
            default:          decode_key = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/game_flow_ctrl_cmd_fifo.sv
// Synchronous command FIFO with flush; pointers carry a wrap bit
// so full and empty are distinguished without a separate counter.
module game_flow_ctrl_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW])
                  && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// Key-to-command sequencer: decodes PS/2 make codes, queues them and
// issues one per game tick; owns the title/play/game-over flow.
module game_flow_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_TICKS = 100
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    key_code,
    input  logic                          make_pulse,
    input  logic                          tick,
    input  logic                          game_over,
    input  logic                          cmd_ready,
    output logic                          cmd_valid,
    output logic [3:0]                    cmd_code,
    output logic                          show_title,
    output logic                          show_over,
    output logic                          game_restart,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);
    import game_flow_ctrl_pkg::*;

    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [3:0]    key_cmd;
    logic [3:0]    fifo_head;
    logic          key_hit;
    logic          in_play;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          drop;
    logic          flush;

    always_comb begin
        key_cmd = decode_key(key_code);
        key_hit = make_pulse && (key_cmd != CMD_NONE);
        in_play = (state == ST_PLAY) && !game_over;
        flush   = (state == ST_PLAY) && game_over;
        pop     = in_play && tick && !cmd_valid && !fifo_empty;
        push    = in_play && key_hit && (!fifo_full || pop);
        drop    = in_play && key_hit && fifo_full && !pop;
    end

    game_flow_ctrl_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (key_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_TITLE;
            show_title   <= 1'b1;
            show_over    <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_code     <= CMD_NONE;
            game_restart <= 1'b0;
            drop_count   <= 8'd0;
            hold_cnt     <= '0;
        end else begin
            game_restart <= 1'b0;
            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            unique case (state)
                ST_TITLE: begin
                    if (make_pulse) begin
                        state        <= ST_PLAY;
                        show_title   <= 1'b0;
                        game_restart <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (game_over) begin
                        state     <= ST_OVER_HOLD;
                        show_over <= 1'b1;
                        cmd_valid <= 1'b0;
                        hold_cnt  <= '0;
                    end else if (pop) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= fifo_head;
                    end else if (cmd_valid && cmd_ready) begin
                        cmd_valid <= 1'b0;
                    end
                end
                ST_OVER_HOLD: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= ST_OVER;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                ST_OVER: begin
                    if (make_pulse) begin
                        state      <= ST_TITLE;
                        show_over  <= 1'b0;
                        show_title <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a queue-based reference model.
module tb_game_flow_ctrl;
    localparam int DEPTH = 4;
    localparam int HOLD  = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] key_code = 8'h00;
    logic       make_pulse = 1'b0;
    logic       tick = 1'b0;
    logic       game_over = 1'b0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [3:0] cmd_code;
    logic       show_title;
    logic       show_over;
    logic       game_restart;
    logic [2:0] fifo_level;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    game_flow_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .HOLD_TICKS (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_code     (key_code),
        .make_pulse   (make_pulse),
        .tick         (tick),
        .game_over    (game_over),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_code     (cmd_code),
        .show_title   (show_title),
        .show_over    (show_over),
        .game_restart (game_restart),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: flow phase, command queue, output register
    localparam int M_TITLE = 0;
    localparam int M_PLAY  = 1;
    localparam int M_HOLD  = 2;
    localparam int M_OVER  = 3;

    byte unsigned key_tab [13] = '{8'h6B, 8'h1C, 8'h74, 8'h23, 8'h75,
        8'h1D, 8'h72, 8'h1B, 8'h29, 8'h2D, 8'h16, 8'h1E, 8'h26};
    byte unsigned cmd_tab [13] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 6, 7, 8, 9};

    int         m_phase = M_TITLE;
    logic [3:0] m_q [$];
    bit         m_valid = 0;
    logic [3:0] m_code = 0;
    bit         m_restart = 0;
    int         m_drops = 0;
    int         m_ticks = 0;
    bit         m_init = 0;

    function automatic int model_cmd(input logic [7:0] k);
        model_cmd = 0;
        for (int i = 0; i < 13; i++)
            if (k == key_tab[i]) model_cmd = cmd_tab[i];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_init = 1;
            m_phase = M_TITLE;
            m_q.delete();
            m_valid = 0;
            m_code = 0;
            m_restart = 0;
            m_drops = 0;
            m_ticks = 0;
        end else begin
            m_restart = 0;
            case (m_phase)
                M_TITLE: if (make_pulse) begin
                    m_phase = M_PLAY;
                    m_restart = 1;
                end
                M_PLAY: if (game_over) begin
                    m_q.delete();
                    m_valid = 0;
                    m_ticks = 0;
                    m_phase = M_HOLD;
                end else begin
                    if (m_valid) begin
                        if (cmd_ready) m_valid = 0;
                    end else if (tick && m_q.size() > 0) begin
                        m_code = m_q.pop_front();
                        m_valid = 1;
                    end
                    if (make_pulse && model_cmd(key_code) != 0) begin
                        if (m_q.size() < DEPTH)
                            m_q.push_back(4'(model_cmd(key_code)));
                        else if (m_drops < 255)
                            m_drops++;
                    end
                end
                M_HOLD: if (tick) begin
                    m_ticks++;
                    if (m_ticks == HOLD) m_phase = M_OVER;
                end
                default: if (make_pulse) m_phase = M_TITLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("cmp_valid", cmd_valid, m_valid);
            if (m_valid) check("cmp_code", cmd_code, m_code);
            check("cmp_title", show_title, m_phase == M_TITLE);
            check("cmp_over", show_over, m_phase >= M_HOLD);
            check("cmp_restart", game_restart, m_restart);
            check("cmp_level", fifo_level, m_q.size());
            check("cmp_drops", drop_count, m_drops);
        end
    end

    task automatic cyc(input bit mk, input logic [7:0] kc, input bit tk);
        make_pulse = mk;
        key_code = kc;
        tick = tk;
        @(negedge clk);
        make_pulse = 1'b0;
        tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] t3_keys [6] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D, 8'h16};
    logic [3:0] t2_exp [3] = '{4'd1, 4'd2, 4'd5};

    initial begin
        repeat (2) @(negedge clk);
        check("t1_rst_title", show_title, 1);
        check("t1_rst_over", show_over, 0);
        check("t1_rst_valid", cmd_valid, 0);
        check("t1_rst_code", cmd_code, 0);
        check("t1_rst_level", fifo_level, 0);
        check("t1_rst_drops", drop_count, 0);
        check("t1_rst_restart", game_restart, 0);
        reset = 1'b0;
        idle(1);
        cyc(1'b1, 8'h29, 1'b0);
        check("t1_restart", game_restart, 1);
        check("t1_title_off", show_title, 0);
        check("t1_level", fifo_level, 0);
        idle(1);
        check("t1_restart_end", game_restart, 0);

        cmd_ready = 1'b1;
        cyc(1'b1, 8'h6B, 1'b0);
        cyc(1'b1, 8'h74, 1'b0);
        cyc(1'b1, 8'h29, 1'b0);
        check("t2_level", fifo_level, 3);
        idle(2);
        check("t2_no_tick", cmd_valid, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            check("t2_valid", cmd_valid, 1);
            check("t2_code", cmd_code, t2_exp[i]);
            idle(1);
            check("t2_accept", cmd_valid, 0);
        end
        check("t2_empty", fifo_level, 0);

        cmd_ready = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, t3_keys[i], 1'b0);
        check("t3_level", fifo_level, 4);
        check("t3_drops", drop_count, 2);
        cyc(1'b0, 8'h00, 1'b1);
        check("t3_valid", cmd_valid, 1);
        check("t3_code", cmd_code, 1);
        repeat (2) begin
            cyc(1'b0, 8'h00, 1'b1);
            idle(1);
        end
        check("t3_hold_valid", cmd_valid, 1);
        check("t3_hold_code", cmd_code, 1);
        check("t3_hold_level", fifo_level, 3);
        cyc(1'b1, 8'h1E, 1'b0);
        check("t3_refill", fifo_level, 4);
        cmd_ready = 1'b1;
        idle(1);
        check("t3_accept", cmd_valid, 0);
        cmd_ready = 1'b0;

        cyc(1'b1, 8'h26, 1'b1);
        check("t4_level", fifo_level, 4);
        check("t4_drops", drop_count, 2);
        check("t4_valid", cmd_valid, 1);
        check("t4_code", cmd_code, 2);
        cyc(1'b1, 8'h5A, 1'b0);
        check("t4_unmapped", drop_count, 2);
        cyc(1'b1, 8'h16, 1'b0);
        check("t4_full_drop", drop_count, 3);

        cmd_ready = 1'b1;
        idle(1);
        cmd_ready = 1'b0;
        cyc(1'b0, 8'h00, 1'b1);
        check("t5_pre_code", cmd_code, 3);
        check("t5_pre_level", fifo_level, 3);
        game_over = 1'b1;
        idle(1);
        game_over = 1'b0;
        check("t5_flush", fifo_level, 0);
        check("t5_valid", cmd_valid, 0);
        check("t5_over", show_over, 1);
        for (int i = 0; i < HOLD; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            if (i < HOLD - 1) cyc(1'b1, 8'h29, 1'b0);
        end
        check("t5_hold_title", show_title, 0);
        check("t5_hold_over", show_over, 1);
        cyc(1'b1, 8'h29, 1'b0);
        check("t5_back_title", show_title, 1);
        check("t5_back_over", show_over, 0);
        game_over = 1'b1;
        idle(1);
        game_over = 1'b0;
        check("t5_title_go", show_title, 1);
        check("t5_drops_kept", drop_count, 3);

        cyc(1'b1, 8'h5A, 1'b0);
        check("t6_restart", game_restart, 1);
        check("t6_level", fifo_level, 0);
        cyc(1'b1, 8'h29, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        check("t6_valid", cmd_valid, 1);
        reset = 1'b1;
        idle(1);
        check("t6_rst_valid", cmd_valid, 0);
        check("t6_rst_code", cmd_code, 0);
        check("t6_rst_title", show_title, 1);
        check("t6_rst_drops", drop_count, 0);
        check("t6_rst_level", fifo_level, 0);
        reset = 1'b0;
        cyc(1'b1, 8'h5A, 1'b0);
        check("t6_unmapped_go", show_title, 0);
        check("t6_restart2", game_restart, 1);

        repeat (262) cyc(1'b1, 8'h1C, 1'b0);
        check("sat_drops", drop_count, 255);
        check("sat_level", fifo_level, 4);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
